// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the unified memory and mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] rdata0;
  logic          ack0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata1;
  logic          ack1;
  logic          lock1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output rdata0, ack0, rdata1, ack1,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  rdata0, ack0, rdata1, ack1,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the unified MIPS memory.
// One transaction per IDLE -> ACCESS -> RESP pass; port 1 may hold a bounded lock.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_lockActive;
  logic [CW-1:0] r_burstCnt;
  logic [AW-1:0] r_memAddr;
  logic [DW-1:0] r_memWdata;
  logic          r_memWe;
  logic          r_isWrite;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_ack0;
  logic          r_ack1;

  logic          w_anyReq;
  logic          w_grant;
  logic          w_selWe;
  logic [AW-1:0] w_selAddr;
  logic [DW-1:0] w_selWdata;
  logic [CW-1:0] w_burstNext;

  // An active lock overrides round-robin; otherwise ties go to the port that did not go last.
  always_comb begin
    w_anyReq = bus.req0 | bus.req1;
    if (r_lockActive && bus.req1) begin
      w_grant = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      w_grant = ~r_last;
    end else begin
      w_grant = bus.req1;
    end
    w_selWe     = w_grant ? bus.we1    : bus.we0;
    w_selAddr   = w_grant ? bus.addr1  : bus.addr0;
    w_selWdata  = w_grant ? bus.wdata1 : bus.wdata0;
    w_burstNext = r_burstCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_lockActive <= 1'b0;
      r_burstCnt   <= '0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_memWe      <= 1'b0;
      r_isWrite    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.req1) begin
            r_lockActive <= 1'b0;
            r_burstCnt   <= '0;
          end
          if (w_anyReq) begin
            r_owner    <= w_grant;
            r_isWrite  <= w_selWe;
            r_memWe    <= w_selWe;
            r_memAddr  <= w_selAddr;
            r_memWdata <= w_selWdata;
            r_state    <= ACCESS;
            // Reaching MAX_BURST releases the lock; last=1 after RESP then hands the next tie to port 0.
            if (w_grant) begin
              if (bus.lock1 && (w_burstNext < CW'(MAX_BURST))) begin
                r_lockActive <= 1'b1;
                r_burstCnt   <= w_burstNext;
              end else begin
                r_lockActive <= 1'b0;
                r_burstCnt   <= '0;
              end
            end
          end
        end
        ACCESS: begin
          r_memWe <= 1'b0;
          if (!r_isWrite) begin
            if (r_owner) begin
              r_rdata1 <= bus.mem_rdata;
            end else begin
              r_rdata0 <= bus.mem_rdata;
            end
          end
          r_ack0  <= ~r_owner;
          r_ack1  <= r_owner;
          r_state <= RESP;
        end
        RESP: begin
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.mem_we    = r_memWe;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected (port, rdata) pairs are queued at stimulus
// time and retired by a monitor on every ack.
module tb_mem_arbiter;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } expect_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] memArray [0:255];
  logic          memLoad = 1'b0;
  logic [7:0]    memLoadIdx = 8'd0;
  logic [DW-1:0] memLoadData = '0;

  assign bus.mem_rdata = memArray[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (memLoad) begin
      memArray[memLoadIdx] <= memLoadData;
    end else if (bus.mem_we) begin
      memArray[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  int            compared = 0;
  int            mismatched = 0;
  int            weCycles = 0;
  expect_t       sbQueue [$];
  expect_t       monExpect;
  logic [DW-1:0] shadowRdata [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every ack must match the oldest queued expectation in port and returned data.
  always @(negedge clk) begin
    if (bus.mem_we) weCycles++;
    if (bus.ack0 || bus.ack1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedAck", 32'({bus.ack1, bus.ack0}), 32'd0);
      end else begin
        monExpect = sbQueue.pop_front();
        checkOutput("ackPort", 32'({bus.ack1, bus.ack0}), monExpect.port ? 32'd2 : 32'd1);
        checkOutput("ackRdata", monExpect.port ? bus.rdata1 : bus.rdata0, monExpect.rdata);
      end
    end
  end

  task automatic pushExpect(input logic port, input logic [DW-1:0] rdata);
    expect_t e;
    e.port  = port;
    e.rdata = rdata;
    shadowRdata[port] = rdata;
    sbQueue.push_back(e);
  endtask

  task automatic loadWord(input logic [7:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    memLoad     = 1'b1;
    memLoadIdx  = idx;
    memLoadData = data;
    @(negedge clk);
    memLoad = 1'b0;
  endtask

  task automatic clearInputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.lock1 = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ack0"}, 32'(bus.ack0), 32'd0);
    checkOutput({tag, "Ack1"}, 32'(bus.ack1), 32'd0);
    checkOutput({tag, "MemWe"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "MemAddr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, "MemWdata"}, bus.mem_wdata, 32'd0);
    checkOutput({tag, "Rdata0"}, bus.rdata0, 32'd0);
    checkOutput({tag, "Rdata1"}, bus.rdata1, 32'd0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    clearInputs();
    shadowRdata[0] = '0;
    shadowRdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkResetState(tag);
  endtask

  // Single-port transaction: wait for the matching ack, then drop req in the ack cycle.
  task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] expRdata);
    bit seen = 1'b0;
    @(negedge clk);
    pushExpect(port, we ? shadowRdata[port] : expRdata);
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = port ? bus.ack1 : bus.ack0;
    end
    checkOutput("ackSeen", 32'(seen), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // Both ports read continuously; ack order is checked by the scoreboard, spacing here.
  task automatic runBoth(input int nAcks, input logic lockIn, input bit dropLock, input string tag);
    int seen = 0;
    int lastCycle = 0;
    int cyc = 0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h40;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h80;
    bus.lock1 = lockIn;
    for (int i = 0; i < 200 && seen < nAcks; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        if (seen == 0) checkOutput({tag, "FirstAck"}, 32'(cyc), 32'd2);
        else checkOutput({tag, "Spacing"}, 32'(cyc - lastCycle), 32'd3);
        lastCycle = cyc;
        seen++;
        if (dropLock && bus.ack1) bus.lock1 = 1'b0;
      end
    end
    checkOutput({tag, "AckCount"}, 32'(seen), nAcks);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.lock1 = 1'b0;
    @(negedge clk);
    checkOutput({tag, "SbEmpty"}, 32'(sbQueue.size()), 32'd0);
  endtask

  initial begin
    clearInputs();
    shadowRdata[0] = '0;
    shadowRdata[1] = '0;
    loadWord(8'h00, 32'h0);
    loadWord(8'h10, 32'hDEADBEEF);
    loadWord(8'h20, 32'h0);
    loadWord(8'h40, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    checkResetState("init");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idleMemWe", 32'(bus.mem_we), 32'd0);
      checkOutput("idleAck", 32'({bus.ack1, bus.ack0}), 32'd0);
    end

    @(negedge clk);
    pushExpect(1'b0, 32'hDEADBEEF);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h40;
    @(negedge clk);
    checkOutput("readMemAddr", bus.mem_addr, 32'h40);
    checkOutput("readAckEarly", 32'(bus.ack0), 32'd0);
    @(negedge clk);
    checkOutput("readAck0", 32'(bus.ack0), 32'd1);
    checkOutput("readAck1", 32'(bus.ack1), 32'd0);
    checkOutput("readRdata0", bus.rdata0, 32'hDEADBEEF);
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("readAckOnce", 32'(bus.ack0), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    weCycles = 0;
    applyStimulus(1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0);
    checkOutput("writeWeCycles", 32'(weCycles), 32'd1);
    checkOutput("writeRdata1Kept", bus.rdata1, 32'hDEADBEEF);
    checkOutput("writeMem", memArray[8'h20], 32'h12345678);
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0, 32'h12345678);
    checkOutput("readBackRdata1", bus.rdata1, 32'hDEADBEEF);

    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h100; bus.wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("rstWeBefore", 32'(bus.mem_we), 32'd1);
    #2;
    reset = 1'b0;
    bus.req0 = 1'b0;
    #1;
    checkOutput("rstWeAsync", 32'(bus.mem_we), 32'd0);
    shadowRdata[0] = '0;
    shadowRdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkResetState("midRst");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("midRstNoAck", 32'({bus.ack1, bus.ack0}), 32'd0);
    end
    checkOutput("midRstLost", memArray[8'h40], 32'h0);

    pushExpect(1'b0, 32'hDEADBEEF);
    pushExpect(1'b1, 32'h12345678);
    pushExpect(1'b0, 32'hDEADBEEF);
    pushExpect(1'b1, 32'h12345678);
    runBoth(4, 1'b0, 1'b0, "rr");

    doReset("rstLock");
    pushExpect(1'b0, 32'hDEADBEEF);
    for (int i = 0; i < MAX_BURST; i++) pushExpect(1'b1, 32'h12345678);
    pushExpect(1'b0, 32'hDEADBEEF);
    runBoth(MAX_BURST + 2, 1'b1, 1'b0, "lock");

    doReset("rstDrop");
    pushExpect(1'b0, 32'hDEADBEEF);
    pushExpect(1'b1, 32'h12345678);
    pushExpect(1'b1, 32'h12345678);
    pushExpect(1'b0, 32'hDEADBEEF);
    runBoth(4, 1'b1, 1'b1, "lockDrop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single unified instruction/data memory of the multicycle MIPS core. Port 0 serves the multicycle datapath: instruction fetch and load/store, driven from the controller's iord/memwrite phase. Port 1 serves a memory loader/DMA engine. The block serialises accesses, drives the memory's address/write-data/write-enable, returns read data with a one-cycle ack, and applies round-robin fairness with an optional bounded lock for port 1 bursts.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive locked grants to port 1 (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 byte address
- wdata0  in  DW  port 0 write data
- rdata0  out  DW  port 0 read data, registered
- ack0  out  1  port 0 one-cycle completion pulse
- req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1
- lock1  in  1  port 1 requests to keep ownership for its next transaction
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable (memory writes on rising edge)
- mem_rdata  in  DW  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant port != last. Exception: lock_active forces grant to port 1 whenever req1=1. On grant, latch owner, we, addr, wdata; go to ACCESS.
- ACCESS: mem_addr/mem_wdata come from the latched registers. mem_we = latched we (high only in this state). At the end of the cycle, if read, rdata<owner> <= mem_rdata. Then go to RESP.
- RESP: ack<owner> = 1 for exactly this cycle; reqs ignored. Set last <= owner. Then go to IDLE.
- rdataX holds its value until the next completed read by port X. Writes leave rdataX unchanged.
- Lock:
  - burst_cnt (width clog2(MAX_BURST)+1) counts port-1 grants.
  - On a port-1 grant with lock1=1, if the count after increment < MAX_BURST, lock_active=1.
  - lock_active clears, and burst_cnt resets to 0, on: a port-1 grant with lock1=0; MAX_BURST grants reached; or IDLE with req1=0.
  - After the forced release, port 0 wins the next tie.
- Outside ACCESS: mem_we=0; mem_addr/mem_wdata keep their latched values.
- Requester rule: a requester deasserts req, or presents a new transaction, in the cycle after its ack. A req still high in the next IDLE is a new transaction.

## Timing
- Request sampled high in IDLE at edge k: ACCESS during cycle k+1, ack high during cycle k+2, rdata valid from cycle k+2.
- Back-to-back throughput: one transaction per 3 cycles.
- Both requesting continuously: grants alternate 0,1,0,1…; no starvation beyond one transaction.
- Reset values, asserted asynchronously: state=IDLE, ack0=ack1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, last=1 (port 0 wins first tie), lock_active=0, burst_cnt=0.
- Reset mid-ACCESS: mem_we drops immediately. No ack is issued and the transaction is lost; the requester reissues.
- Req deasserted before ack (protocol violation): the transaction still completes and ack still pulses.

## Test plan
- Reset: assert reset=0 mid-ACCESS of a write. mem_we goes 0 with no clock edge; after release all outputs are 0 and no ack appears.
- Single read: memory word 0x40 = 0xDEADBEEF; req0=1, we0=0, addr0=0x40 at edge k. mem_addr=0x40 in k+1, ack0=1 in k+2 only, rdata0=0xDEADBEEF; ack1 stays 0.
- Write then read: port 1 writes 0x12345678 to 0x80. mem_we=1 for exactly one cycle. A following port-0 read of 0x80 returns 0x12345678, and rdata1 is unchanged.
- Contention after reset: req0 and req1 both held high. Ack order is 0,1,0,1 with acks 3 cycles apart.
- Lock burst, MAX_BURST=4: req0 and req1 high, lock1=1. After the current owner finishes, port 1 receives 4 consecutive grants, then port 0 is granted. With lock1 dropped after 2 grants, port 0 is granted next.
- Idle stability: both req low for 10 cycles. mem_we=0, no acks, state stays IDLE.
